// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned CNT_W     = $clog2(WIDTH_DEF);

    // Counter width for an arbitrary operand width; at least one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full subtractor: D = A - B - Bin, Bout = borrow out.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: A - B - Bin, LSB first, one bit per enabled clock.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   Q
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] diff;
    logic             bor;
    logic [CW-1:0]    cnt;

    logic             load;
    logic             step;
    logic             last;
    logic             d_bit;
    logic             bout;

    full_subtractor u_fs (
        .A    (sa[0]),
        .B    (sb[0]),
        .Bin  (bor),
        .D    (d_bit),
        .Bout (bout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes; nothing advances while enable is low.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        load    = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    step = 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        last    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            diff <= '0;
            bor  <= 1'b0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            Q    <= '0;
        end else if (enable) begin
            busy <= (state_d == RUN);
            done <= last;
            if (load) begin
                sa  <= A;
                sb  <= B;
                bor <= Bin;
                cnt <= '0;
            end
            if (step) begin
                diff <= {d_bit, diff[WIDTH-1:1]};
                sa   <= sa >> 1;
                sb   <= sb >> 1;
                bor  <= bout;
                cnt  <= cnt + CW'(1);
            end
            // Final bit bypasses the difference register straight into Q.
            if (last) begin
                Q <= {bout, d_bit, diff[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial ripple-borrow subtractor. It computes A − B − Bin one bit per enabled clock, LSB first, using a single 1-bit full-subtractor cell and a registered borrow. It is the inverse-operation companion of the team's ripple-carry adder: same operand widths and the same registered {borrow/carry, result} output word. The adder's parallel carry chain is traded for WIDTH cycles of latency and a start/done handshake.

## Interface
- WIDTH, 4: operand width in bits; legal range 2 to 32.
- clk  in  1  the only clock; all logic updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  global clock-enable; when low, every register holds its value.
- start  in  1  request a subtraction; honoured only in IDLE with enable high.
- A  in  WIDTH  minuend; sampled when start is accepted.
- B  in  WIDTH  subtrahend; sampled when start is accepted.
- Bin  in  1  borrow-in; sampled when start is accepted.
- busy  out  1  high while a subtraction is in progress (state RUN).
- done  out  1  result-valid pulse.
- Q  out  WIDTH+1  result word: Q[WIDTH] is the borrow-out; Q[WIDTH-1:0] is the difference, modulo 2^WIDTH.

## Operation
- Reset (rst_n low at an edge):
  - state becomes IDLE;
  - busy, done and Q become 0;
  - operand shift registers, borrow flop and bit counter are cleared.
  - Reset takes priority over enable.
- IDLE, start & enable:
  - load A→sa and B→sb, Bin→borrow flop, count=0;
  - go to RUN.
  - Q keeps its previous value until the new result is written.
- RUN, each edge with enable high:
  - d = sa[0]^sb[0]^bor
  - bor' = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&bor)
  - Shift d into the MSB of the difference register; shift sa and sb right by one; count++.
- RUN, on the edge that processes bit WIDTH−1:
  - Q ← {bor', diff};
  - done ← 1;
  - state → IDLE.
- done is high for exactly one enabled cycle. It clears at the next enabled edge. If enable drops while done is high, done holds until the next enabled edge.
- start while in RUN is ignored: no restart and no error.
- start in the cycle where done is high is accepted, because the state is IDLE. done clears on that same edge.
- Arithmetic rules:
  - Q[WIDTH-1:0] = (A − B − Bin) mod 2^WIDTH.
  - Q[WIDTH] = 1 iff A < B + Bin (unsigned).
- enable low during RUN pauses the calculation. The result is unchanged and latency grows by exactly the number of disabled cycles.
- rst_n low during RUN aborts the operation. No done is produced for the aborted operation.

## Timing
- Latency is WIDTH+1 rising edges, with no enable gaps:
  - edge k samples start;
  - edges k+1 … k+WIDTH process bits 0 … WIDTH−1;
  - done and the new Q are visible after edge k+WIDTH.
- busy is high from after edge k until after edge k+WIDTH.
- Maximum throughput is one result per WIDTH+1 cycles, reached by asserting start during the done cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package serial_sub_pkg holds:
  - typedef enum state_t {IDLE, RUN};
  - a localparam for the counter width, $clog2(WIDTH).
- Sub-module full_subtractor is purely combinational:
  - inputs A, B, Bin;
  - outputs D and Bout.
  - It is instantiated once in the datapath.
- The top level contains the FSM, shift registers, borrow flop, counter and output register.

## Test plan
All scenarios use WIDTH=4.
- A=9, B=3, Bin=0, enable held high → busy for 4 cycles; done after edge k+4; Q=5'b00110.
- A=3, B=9, Bin=0 → Q=5'b11010 (difference 10, borrow out 1).
- A=0, B=0, Bin=1 → Q=5'b11111. Also A=15, B=15, Bin=0 → Q=5'b00000.
- A=12, B=5, enable low for 2 cycles mid-RUN → done after edge k+6; Q=5'b00111. A start pulse during RUN is ignored.
- rst_n low for one cycle mid-RUN → busy, done and Q are 0 on the next edge. No done follows. A new start afterwards completes normally.
- Back-to-back:
  - first operation 7−2 → Q=5'b00101;
  - start asserted in its done cycle with 2−7;
  - second done follows 5 edges later with Q=5'b11011;
  - no cycle has done high for two consecutive enabled edges.
